// File: rtl/bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared definitions for the CPU data-bus controller:
//   - state_e          : controller FSM states (IDLE, BUSY, DONE)
//   - NSLV             : number of decoded slaves
//   - SEL_HI / SEL_LO  : CPU address bits that pick the slave
//   - ERR_DATA_DEFAULT : read data returned when a slave never answers
//   - WD_W             : watchdog counter width (TIMEOUT up to 65535)
//   - sel_onehot()     : slave index -> one-hot strobe vector
// ---------------------------------------------------------------------------
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NSLV   = 4;
    localparam int SEL_HI = 31;
    localparam int SEL_LO = 30;
    localparam int WD_W   = 16;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [NSLV-1:0] sel_onehot(input logic [SEL_HI-SEL_LO:0] sel);
        logic [NSLV-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_ctrl_if
// Bundles the CPU memory port, the shared slave bus and the error report.
// Modports:
//   master : view of the bus controller (drives slave strobes, CPU ack/data)
//   slave  : view of the surroundings (CPU request + slave responses)
// Signals:
//   cpu_addr/cpu_dat_o/cpu_we/cpu_stb : CPU request
//   cpu_dat_i/cpu_ack                 : completion back to the CPU
//   s_stb/s_we/s_addr/s_dat_o         : registered slave transaction
//   s_dat_i/s_ack                     : per-slave response (slave k at [32k+:32])
//   err/err_addr                      : sticky timeout flag + first bad address
// ---------------------------------------------------------------------------
interface bus_ctrl_if;
    import bus_ctrl_pkg::*;

    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_dat_o;
    logic               cpu_we;
    logic               cpu_stb;
    logic [31:0]        cpu_dat_i;
    logic               cpu_ack;

    logic [NSLV-1:0]    s_stb;
    logic               s_we;
    logic [31:0]        s_addr;
    logic [31:0]        s_dat_o;
    logic [NSLV*32-1:0] s_dat_i;
    logic [NSLV-1:0]    s_ack;

    logic               err;
    logic [31:0]        err_addr;

    modport master (
        input  cpu_addr, cpu_dat_o, cpu_we, cpu_stb, s_dat_i, s_ack,
        output cpu_dat_i, cpu_ack, s_stb, s_we, s_addr, s_dat_o, err, err_addr
    );

    modport slave (
        output cpu_addr, cpu_dat_o, cpu_we, cpu_stb, s_dat_i, s_ack,
        input  cpu_dat_i, cpu_ack, s_stb, s_we, s_addr, s_dat_o, err, err_addr
    );

endinterface

// File: rtl/bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Loadable down-counter guarding one bus transaction.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : reload value (number of cycles allowed)
//   dec_i        : count down by one (saturates at zero)
//   expire_o     : high while the count is 1, i.e. the last allowed cycle
// ---------------------------------------------------------------------------
module bus_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Loaded with N on BUSY entry, so a count of 1 marks the N-th BUSY cycle.
    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl
// Data-bus controller between a single-cycle CPU and four slaves.
// A level-style CPU request (cpu_stb | cpu_we) is turned into one registered
// slave transaction selected by cpu_addr[31:30]. Completion is a one-cycle
// cpu_ack with latched read data. A watchdog forces completion with
// ERR_DATA if the selected slave never acknowledges, and records the first
// such address in a sticky error report.
// Parameters:
//   TIMEOUT  : BUSY cycles without ack before forced completion (1..65535)
//   ERR_DATA : read data returned on a timed-out access
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : bus_ctrl_if.master (CPU port, slave bus, err/err_addr)
// ---------------------------------------------------------------------------
module bus_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    bus_ctrl_if.master bus
);

    localparam int SW = SEL_HI - SEL_LO + 1;

    state_e          state_q;
    logic [SW-1:0]   sel_q;
    logic [NSLV-1:0] s_stb_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     err_addr_q;

    logic            req;
    logic [SW-1:0]   sel_d;
    logic [31:0]     s_rd [NSLV];
    logic            sel_ack;
    logic [31:0]     sel_rd;
    logic            wd_load;
    logic            wd_dec;
    logic            wd_expire;

    assign req   = bus.cpu_stb | bus.cpu_we;
    assign sel_d = bus.cpu_addr[SEL_HI:SEL_LO];

    // Split the flat slave read bus into one word per slave.
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_rd
            assign s_rd[gi] = bus.s_dat_i[32*gi +: 32];
        end
    endgenerate

    // Only the latched slave can complete the access; others are ignored.
    assign sel_ack = bus.s_ack[sel_q];
    assign sel_rd  = s_rd[sel_q];

    assign wd_load = (state_q == ST_IDLE) && req;
    assign wd_dec  = (state_q == ST_BUSY) && !sel_ack;

    bus_watchdog #(
        .W (WD_W)
    ) u_wd (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wd_load),
        .load_val_i (WD_W'(TIMEOUT)),
        .dec_i      (wd_dec),
        .expire_o   (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            s_stb_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        // cpu_we wins when both strobes are high.
                        we_q    <= bus.cpu_we;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_dat_o;
                        sel_q   <= sel_d;
                        s_stb_q <= sel_onehot(sel_d);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ack is tested first so a same-cycle ack beats the watchdog.
                    if (sel_ack) begin
                        rdata_q <= sel_rd;
                        s_stb_q <= '0;
                        state_q <= ST_DONE;
                    end else if (wd_expire) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                        if (!err_q) begin
                            err_addr_q <= addr_q;
                        end
                        s_stb_q <= '0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    s_stb_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Idle cycles without a request retire immediately, so ack is
    // combinational on the request there; DONE gives the one-cycle completion.
    assign bus.cpu_ack   = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);
    assign bus.cpu_dat_i = rdata_q;
    assign bus.s_stb     = s_stb_q;
    assign bus.s_we      = we_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_dat_o   = wdata_q;
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Data-bus controller between the single-cycle CPU's memory/IO port and up to four slaves (data RAM, keyboard, display, timer). It decodes the CPU address to one slave and converts the CPU's level-style STB/WE request into a single registered slave transaction. It returns a one-cycle ACK with latched read data, so the CPU holds its PC and register write until the access completes. A watchdog completes any transaction the addressed slave never acknowledges, so a dead slave cannot hang the CPU.

## Interface
- TIMEOUT, 255: cycles in BUSY without slave ack before forced completion; 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out read.

- clk  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-high
- cpu_addr  in  32  CPU Addr (ALU result)
- cpu_dat_o  in  32  CPU store data
- cpu_we  in  1  CPU store request (sw)
- cpu_stb  in  1  CPU load request (lw)
- cpu_dat_i  out  32  load data to CPU
- cpu_ack  out  1  CPU may commit/advance this cycle
- s_stb  out  4  one-hot slave strobe
- s_we  out  1  write qualifier, shared
- s_addr  out  32  latched address, shared
- s_dat_o  out  32  latched store data, shared
- s_dat_i  in  4x32 (128, slave k at [32k+31:32k])  slave read data
- s_ack  in  4  per-slave acknowledge
- err  out  1  sticky timeout flag
- err_addr  out  32  address of first timed-out access

## Operation
- Request = cpu_stb | cpu_we. Slave select = cpu_addr[31:30]; all four indices are mapped.
- States: IDLE, BUSY, DONE.
- IDLE, no request: cpu_ack = 1, combinational. Non-memory instructions retire every cycle.
- IDLE, request: cpu_ack = 0. Latch addr, store data, we, and slave index. Load the watchdog with TIMEOUT. Go to BUSY.
- BUSY: s_stb[sel] = 1, other bits 0. s_we/s_addr/s_dat_o come from the latches.
  - s_ack[sel] = 1: capture s_dat_i[sel] into rdata. Go to DONE.
  - Otherwise, watchdog = 1: rdata = ERR_DATA. Set err. Record err_addr only if err was previously 0. Go to DONE.
  - Otherwise decrement the watchdog.
  - s_ack from unselected slaves is ignored.
- DONE: cpu_ack = 1, cpu_dat_i = rdata, s_stb = 0. Go to IDLE unconditionally. A back-to-back memory instruction is seen fresh in IDLE.
- cpu_dat_i = rdata at all times. The CPU uses it only when cpu_ack is high.
- err and err_addr clear only on reset.

## Timing
- Reset values: state IDLE, s_stb 0, s_we 0, s_addr 0, s_dat_o 0, rdata 0, err 0, err_addr 0. cpu_ack is 1 (IDLE with no request after reset).
- Zero-wait slave (ack in its first BUSY cycle): IDLE→BUSY→DONE. Access takes 3 cycles; cpu_ack is high in the 3rd.
- Slave acking n cycles after strobe start: n+2 cycles total.
- Timeout completes after TIMEOUT BUSY cycles; cpu_ack follows 1 cycle later.
- Ack arriving in the same cycle as watchdog = 1: ack wins, no error.
- s_stb is held high for exactly the BUSY cycles; at most one transaction is outstanding.
- Slaves sample s_we/s_addr/s_dat_o while s_stb is high. These values stay stable from BUSY entry until the next IDLE→BUSY transition.
- Reset asserted in BUSY/DONE: at the next edge the state is IDLE, s_stb is 0, and the transaction is abandoned without cpu_ack. A late s_ack is ignored.
- cpu_we and cpu_stb both high: treated as a write (s_we = 1).

## Structure
- Shared package: state encoding (IDLE, BUSY, DONE), NSLV = 4, SEL_HI/SEL_LO = 31/30, default ERR_DATA.
- One sub-module, bus_watchdog: loadable down-counter with an expire output.
- Decode, mux, and FSM live in bus_ctrl.

## Test plan
- Non-memory cycles: request low for 10 cycles → cpu_ack = 1 every cycle, s_stb = 0.
- Zero-wait read: cpu_stb, addr 0x0000_0010, slave 0 acks in its first strobe cycle with 0x1234_5678 → s_stb = 0001 for 1 cycle; cpu_ack in cycle 3 with cpu_dat_i = 0x1234_5678.
- Wait-state write: cpu_we, addr 0x8000_0004, data 0xA5A5_A5A5, slave 2 acks after 4 cycles → s_stb = 0100 for 4 cycles, s_we = 1, s_dat_o = 0xA5A5_A5A5; cpu_ack at cycle 6.
- Timeout: TIMEOUT = 8, read to 0xC000_0000, no ack → cpu_ack after 8 BUSY cycles, cpu_dat_i = 0xDEAD_BEEF, err = 1, err_addr = 0xC000_0000. A second timeout at 0x4000_0000 leaves err_addr unchanged.
- Wrong-slave ack and boundary: select slave 1 while slave 0 acks → no completion. Then slave 1 acks in the same cycle the watchdog expires → normal data returned, err stays 0.
- Reset in BUSY: assert reset mid-access, then slave acks → no cpu_ack pulse, s_stb = 0, state IDLE, outputs at reset values.
